// File: rtl/opb_regbank_pkg.sv
// Shared definitions for the OPB register bank: slave FSM states, register map offsets, CTRL bits.
package opb_regbank_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACK     = 2'd1,
      ST_RECOVER = 2'd2
   } state_t;

   // CTRL bit 0 in byte lane 0 requests a snapshot
   localparam int CTRL_SNAPSHOT_BIT  = 0;
   localparam int CTRL_SNAPSHOT_LANE = 0;

   function automatic int status_offset(input int num_regs);
      return num_regs;
   endfunction

   function automatic int ctrl_offset(input int num_regs);
      return num_regs + 1;
   endfunction

endpackage

// File: rtl/regbank_chan.sv
// One user channel: live capture register, sticky capture flag and, with
// OPB_REGBANK_SNAPSHOT_EN defined, a snapshot register that data reads return.
module regbank_chan
   import opb_regbank_pkg::*;
(
   input  logic        clk,
   input  logic        srst,
   input  logic        valid,
   input  logic [31:0] data_in,
   input  logic        clr,
   input  logic        snap_req,
   output logic [31:0] rd_data,
   output logic        flag
);

   logic [31:0] live_reg;
   logic        flag_reg;

   // A capture in the same cycle as a clear keeps the flag set
   always_ff @(posedge clk) begin
      if (srst) begin
         live_reg <= '0;
         flag_reg <= 1'b0;
      end else begin
         if (valid) begin
            live_reg <= data_in;
            flag_reg <= 1'b1;
         end else if (clr) begin
            flag_reg <= 1'b0;
         end
      end
   end

   assign flag = flag_reg;

`ifdef OPB_REGBANK_SNAPSHOT_EN
   logic [31:0] snap_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         snap_reg <= '0;
      end else if (snap_req) begin
         snap_reg <= live_reg;
      end
   end

   assign rd_data = snap_reg;
`else
   logic unused_snap;
   assign unused_snap = snap_req;
   assign rd_data     = live_reg;
`endif

endmodule

// File: rtl/opb_register_bank_simulink2ppc.sv
// OPB slave register bank: C_NUM_REGS read-only capture channels plus STATUS (W1C) and CTRL.
// Optional snapshot feature is enabled by defining OPB_REGBANK_SNAPSHOT_EN.
module opb_register_bank_simulink2ppc
   import opb_regbank_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR   = 32'h01001200,
   parameter logic [31:0] C_HIGHADDR   = 32'h010012FF,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter int          C_NUM_REGS   = 8,
   parameter string       C_FAMILY     = "virtex5"
) (
   input  logic                      OPB_Clk,
   input  logic                      OPB_Rst,
   input  logic [0:31]               OPB_ABus,
   input  logic [0:3]                OPB_BE,
   input  logic [0:31]               OPB_DBus,
   input  logic                      OPB_RNW,
   input  logic                      OPB_select,
   input  logic                      OPB_seqAddr,
   output logic [0:31]               Sl_DBus,
   output logic                      Sl_xferAck,
   output logic                      Sl_errAck,
   output logic                      Sl_retry,
   output logic                      Sl_toutSup,
   input  logic [32*C_NUM_REGS-1:0]  user_data_in,
   input  logic [C_NUM_REGS-1:0]     user_valid
);

   generate
      if (C_NUM_REGS < 1 || C_NUM_REGS > 30) begin : g_bad_num_regs
         $error("C_NUM_REGS must be in 1..30");
      end
      if (C_OPB_AWIDTH != 32 || C_OPB_DWIDTH != 32) begin : g_bad_width
         $error("only 32-bit OPB address and data widths are supported");
      end
   endgenerate

   localparam int STATUS_OFF = status_offset(C_NUM_REGS);
   localparam int CTRL_OFF   = ctrl_offset(C_NUM_REGS);

   // Bus vectors are big-endian; repack so bit 0 is the LSB
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   assign addr  = OPB_ABus;
   assign wdata = OPB_DBus;
   assign be    = OPB_BE;

   logic        hit;
   logic [31:0] word_offset;
   assign hit         = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
   assign word_offset = (addr - C_BASEADDR) >> 2;

   logic [31:0]           chan_rd [C_NUM_REGS];
   logic [C_NUM_REGS-1:0] flags;
   logic [C_NUM_REGS-1:0] clr_mask_next;
   logic [C_NUM_REGS-1:0] clr_mask_reg;
   logic                  snap_req;
   logic [31:0]           read_value;

   state_t      state_reg;
   logic        xfer_ack_reg;
   logic [31:0] rdata_reg;

   always_comb begin
      read_value = '0;
      for (int i = 0; i < C_NUM_REGS; i++) begin
         if (word_offset == 32'(i)) begin
            read_value = chan_rd[i];
         end
      end
      if (word_offset == 32'(STATUS_OFF)) begin
         read_value[C_NUM_REGS-1:0] = flags;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < C_NUM_REGS; gi++) begin : g_chan
         assign clr_mask_next[gi] = wdata[gi] & be[gi/8];

         regbank_chan u_chan (
            .clk      (OPB_Clk),
            .srst     (OPB_Rst),
            .valid    (user_valid[gi]),
            .data_in  (user_data_in[32*gi +: 32]),
            .clr      (clr_mask_reg[gi]),
            .snap_req (snap_req),
            .rd_data  (chan_rd[gi]),
            .flag     (flags[gi])
         );
      end
   endgenerate

`ifdef OPB_REGBANK_SNAPSHOT_EN
   logic snap_req_reg;
   assign snap_req = snap_req_reg;
`else
   assign snap_req = 1'b0;
`endif

   // Write side effects are latched on the hit and applied at the end of ACK
   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         state_reg    <= ST_IDLE;
         xfer_ack_reg <= 1'b0;
         rdata_reg    <= '0;
         clr_mask_reg <= '0;
`ifdef OPB_REGBANK_SNAPSHOT_EN
         snap_req_reg <= 1'b0;
`endif
      end else begin
         xfer_ack_reg <= 1'b0;
         rdata_reg    <= '0;
         clr_mask_reg <= '0;
`ifdef OPB_REGBANK_SNAPSHOT_EN
         snap_req_reg <= 1'b0;
`endif
         case (state_reg)
            ST_IDLE: begin
               if (hit) begin
                  state_reg    <= ST_ACK;
                  xfer_ack_reg <= 1'b1;
                  rdata_reg    <= OPB_RNW ? read_value : 32'h0;
                  if (!OPB_RNW && word_offset == 32'(STATUS_OFF)) begin
                     clr_mask_reg <= clr_mask_next;
                  end
`ifdef OPB_REGBANK_SNAPSHOT_EN
                  snap_req_reg <= !OPB_RNW && (word_offset == 32'(CTRL_OFF))
                                  && be[CTRL_SNAPSHOT_LANE] && wdata[CTRL_SNAPSHOT_BIT];
`endif
               end
            end
            ST_ACK:     state_reg <= ST_RECOVER;
            ST_RECOVER: state_reg <= ST_IDLE;
            default:    state_reg <= ST_IDLE;
         endcase
      end
   end

   assign Sl_DBus    = rdata_reg;
   assign Sl_xferAck = xfer_ack_reg;
   assign Sl_errAck  = 1'b0;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;

   logic unused_inputs;
   assign unused_inputs = &{1'b0, OPB_seqAddr, wdata, be, 32'(CTRL_OFF)};

endmodule

// File: tb/tb_opb_register_bank_simulink2ppc.sv
// Directed self-checking bench for opb_register_bank_simulink2ppc (honours OPB_REGBANK_SNAPSHOT_EN).
module tb_opb_register_bank_simulink2ppc;

   localparam int          N        = 8;
   localparam logic [31:0] BASE     = 32'h01001200;
   localparam logic [31:0] A_STATUS = BASE + 32'h20;
   localparam logic [31:0] A_CTRL   = BASE + 32'h24;
   localparam logic [31:0] A_SPARE  = BASE + 32'h28;
   localparam logic [31:0] NO_ACK   = 32'hFFFF_FFFF;

   logic            OPB_Clk = 1'b0;
   logic            OPB_Rst = 1'b0;
   logic [0:31]     OPB_ABus = '0;
   logic [0:3]      OPB_BE = '0;
   logic [0:31]     OPB_DBus = '0;
   logic            OPB_RNW = 1'b0;
   logic            OPB_select = 1'b0;
   logic            OPB_seqAddr = 1'b0;
   logic [0:31]     Sl_DBus;
   logic            Sl_xferAck;
   logic            Sl_errAck;
   logic            Sl_retry;
   logic            Sl_toutSup;
   logic [32*N-1:0] user_data_in = '0;
   logic [N-1:0]    user_valid = '0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 OPB_Clk = ~OPB_Clk;

   opb_register_bank_simulink2ppc dut (
      .OPB_Clk      (OPB_Clk),
      .OPB_Rst      (OPB_Rst),
      .OPB_ABus     (OPB_ABus),
      .OPB_BE       (OPB_BE),
      .OPB_DBus     (OPB_DBus),
      .OPB_RNW      (OPB_RNW),
      .OPB_select   (OPB_select),
      .OPB_seqAddr  (OPB_seqAddr),
      .Sl_DBus      (Sl_DBus),
      .Sl_xferAck   (Sl_xferAck),
      .Sl_errAck    (Sl_errAck),
      .Sl_retry     (Sl_retry),
      .Sl_toutSup   (Sl_toutSup),
      .user_data_in (user_data_in),
      .user_valid   (user_valid)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end else begin
         $display("ok   %s = %08h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge OPB_Clk);
      #1;
   endtask

   task automatic do_reset();
      OPB_Rst = 1'b1;
      tick();
      tick();
      OPB_Rst = 1'b0;
   endtask

   task automatic capture(input int ch, input logic [31:0] d);
      user_data_in[ch*32 +: 32] = d;
      user_valid[ch] = 1'b1;
      tick();
      user_valid[ch] = 1'b0;
   endtask

   // One transfer; lat = cycles from select to ack, NO_ACK if none within 4 cycles
   task automatic xfer(input logic rnw, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, output logic [31:0] rd, output logic [31:0] lat);
      OPB_ABus = a;
      OPB_DBus = d;
      OPB_BE = be;
      OPB_RNW = rnw;
      OPB_select = 1'b1;
      lat = NO_ACK;
      rd = '0;
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (Sl_xferAck) begin
            lat = c;
            rd = Sl_DBus;
            break;
         end
      end
      OPB_select = 1'b0;
      OPB_RNW = 1'b0;
      OPB_DBus = '0;
      tick();
      if (lat != NO_ACK) begin
         check("ack_width", {31'b0, Sl_xferAck}, 32'h0);
      end
      tick();
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] rd, lat;
      xfer(1'b1, a, 32'h0, 4'hF, rd, lat);
      check({tag, "_lat"}, lat, 32'd1);
      check(tag, rd, exp);
   endtask

   task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] rd, lat;
      xfer(1'b0, a, d, be, rd, lat);
      check({tag, "_lat"}, lat, 32'd1);
   endtask

   initial begin
      logic [31:0] rd, lat, ack_mask, ack_cnt;

      // Reset state
      OPB_Rst = 1'b1;
      tick();
      check("rst_ack", {31'b0, Sl_xferAck}, 32'h0);
      check("rst_dbus", Sl_DBus, 32'h0);
      tick();
      OPB_Rst = 1'b0;
      rd_chk("rst_ch0", BASE, 32'h0);
      rd_chk("rst_status", A_STATUS, 32'h0);
      check("const_outs", {29'b0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'h0);

      // Capture on ch2 then read it back; bus stays zero outside ACK
      capture(2, 32'hDEADBEEF);
      OPB_ABus = BASE + 32'h8;
      OPB_RNW = 1'b1;
      OPB_BE = 4'hF;
      OPB_select = 1'b1;
      check("pre_ack_dbus", Sl_DBus, 32'h0);
      tick();
      OPB_select = 1'b0;
      check("ch2_ack", {31'b0, Sl_xferAck}, 32'h1);
      check("ch2_data", Sl_DBus, 32'hDEADBEEF);
      tick();
      check("post_ack", {31'b0, Sl_xferAck}, 32'h0);
      check("post_ack_dbus", Sl_DBus, 32'h0);
      tick();

      capture(0, 32'h12345678);
      capture(7, 32'hA5A50F0F);
      rd_chk("ch0_data", BASE, 32'h12345678);
      rd_chk("ch7_data", BASE + 32'h1C, 32'hA5A50F0F);
      wr("ch2_write", BASE + 32'h8, 32'h0BADF00D, 4'hF);
      rd_chk("ch2_ro", BASE + 32'h8, 32'hDEADBEEF);
      rd_chk("ctrl_read", A_CTRL, 32'h0);
      wr("spare_write", A_SPARE, 32'hFFFFFFFF, 4'hF);
      rd_chk("spare_read", A_SPARE, 32'h0);
      rd_chk("top_word", 32'h010012FC, 32'h0);

      // STATUS set / W1C / lane gating / set-wins collision
      do_reset();
      capture(0, 32'h1);
      capture(5, 32'h5);
      rd_chk("status_21", A_STATUS, 32'h21);
      wr("status_w1c", A_STATUS, 32'h01, 4'hF);
      rd_chk("status_20", A_STATUS, 32'h20);
      wr("status_lane_off", A_STATUS, 32'h20, 4'b1110);
      rd_chk("status_gated", A_STATUS, 32'h20);
      user_data_in[31:0] = 32'h77;
      user_valid[0] = 1'b1;
      xfer(1'b0, A_STATUS, 32'h01, 4'hF, rd, lat);
      user_valid[0] = 1'b0;
      check("collide_lat", lat, 32'd1);
      rd_chk("status_collide", A_STATUS, 32'h21);
      wr("status_clr_all", A_STATUS, 32'h21, 4'hF);
      rd_chk("status_00", A_STATUS, 32'h0);

      // Select held for 6 cycles: acks in cycles 2 and 5
      ack_mask = '0;
      ack_cnt = '0;
      OPB_ABus = BASE;
      OPB_RNW = 1'b1;
      OPB_select = 1'b1;
      for (int c = 2; c <= 7; c++) begin
         tick();
         if (c == 7) OPB_select = 1'b0;
         if (Sl_xferAck) begin
            ack_mask[c] = 1'b1;
            ack_cnt++;
         end
      end
      OPB_select = 1'b0;
      tick();
      tick();
      check("held_ack_cnt", ack_cnt, 32'd2);
      check("held_ack_cycles", ack_mask, 32'h24);

      // Snapshot sequence
      capture(0, 32'h1);
      wr("ctrl_snap", A_CTRL, 32'h1, 4'hF);
      capture(0, 32'h2);
`ifdef OPB_REGBANK_SNAPSHOT_EN
      rd_chk("snap_read", BASE, 32'h1);
`else
      rd_chk("snap_read", BASE, 32'h2);
`endif

      // Reset on the hit cycle drops the transfer
      capture(3, 32'hCAFE0003);
      OPB_ABus = BASE + 32'hC;
      OPB_RNW = 1'b1;
      OPB_select = 1'b1;
      OPB_Rst = 1'b1;
      tick();
      OPB_Rst = 1'b0;
      OPB_select = 1'b0;
      ack_cnt = {31'b0, Sl_xferAck};
      for (int c = 0; c < 3; c++) begin
         tick();
         if (Sl_xferAck) ack_cnt++;
      end
      check("rst_hit_noack", ack_cnt, 32'd0);
      rd_chk("rst_ch3", BASE + 32'hC, 32'h0);
      rd_chk("rst_ch0_after", BASE, 32'h0);
      rd_chk("rst_status_after", A_STATUS, 32'h0);

      // Out-of-window addresses get no response
      xfer(1'b1, 32'h01001300, 32'h0, 4'hF, rd, lat);
      check("miss_above", lat, NO_ACK);
      xfer(1'b1, 32'h010011FC, 32'h0, 4'hF, rd, lat);
      check("miss_below", lat, NO_ACK);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
